// File: rtl/uart_rx_core.sv
// UART 8N1 receiver core: synchronizer, mid-bit sampling FSM,
// single-entry output slot with valid/ready, frame and overrun pulses.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          s1;
  logic          rx_s;
  logic          rx_p;

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      s1          <= 1'b1;
      rx_s        <= 1'b1;
      rx_p        <= 1'b1;
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      s1          <= rx_i;
      rx_s        <= s1;
      rx_p        <= rx_s;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (valid_o && ready_i)
        valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_p && !rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7)
              state <= STOP;
            else
              idx <= idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leave mid-stop-bit so the next start edge can resync.
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rx_s) begin
              frame_err_o <= 1'b1;
            end else if (!valid_o || ready_i) begin
              data_o  <= shreg;
              valid_o <= 1'b1;
            end else begin
              overrun_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at 16 clocks per bit:
// stimulus pushes expected events, a monitor pops on each DUT event.
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       busy;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i      (clk),
    .nreset_i   (nreset),
    .rx_i       (rx),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .frame_err_o(ferr),
    .overrun_o  (ovr),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // kind: 0 byte transfer, 1 frame error, 2 overrun
  typedef struct {
    int         kind;
    logic [7:0] d;
  } ev_t;

  ev_t q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  c0 = 0;
  int  rise_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.d    = d;
    q.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input logic [7:0] d);
    ev_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none",
               kind, d);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == 0)
        chk("event_data", int'(d), int'(e.d));
    end
  endtask

  // Monitor samples just after the falling edge, when inputs for
  // the next rising edge are already settled.
  initial begin
    logic       pv;
    logic [7:0] pd;
    logic       px;
    pv = 1'b0;
    pd = 8'h00;
    px = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (nreset && pv && !px) begin
        chk("hold_valid", int'(valid), 1);
        chk("hold_data", int'(data), int'(pd));
      end
      if (valid && !pv)
        rise_cyc = cyc;
      if (valid && ready)
        pop_chk(0, data);
      if (ferr)
        pop_chk(1, 8'h00);
      if (ovr)
        pop_chk(2, 8'h00);
      pv = valid;
      pd = data;
      px = valid && ready;
    end
  end

  task automatic frame(input logic [7:0] b, input bit stop,
                       input int rdy_at, input int rst_at);
    logic [9:0] bits;
    bit         ab;
    bits = {stop, b, 1'b0};
    ab   = 1'b0;
    for (int i = 0; i < 10 * CPB + CPB; i++) begin
      @(negedge clk);
      if (i == 0)
        c0 = cyc;
      if (rst_at >= 0) begin
        if (i == rst_at - 1)
          chk("busy_mid_frame", int'(busy), 1);
        if (i == rst_at) begin
          nreset = 1'b0;
          ab     = 1'b1;
        end
        if (i == rst_at + 2) begin
          chk("rst_valid", int'(valid), 0);
          chk("rst_data", int'(data), 0);
          chk("rst_busy", int'(busy), 0);
          chk("rst_ferr", int'(ferr), 0);
          chk("rst_ovr", int'(ovr), 0);
        end
        if (i == rst_at + 4)
          nreset = 1'b1;
      end
      if (rdy_at >= 0) begin
        if (i == rdy_at)
          ready = 1'b1;
        if (i == rdy_at + 1) begin
          ready = 1'b0;
          chk("reload_valid", int'(valid), 1);
        end
      end
      rx = (ab || i >= 10 * CPB) ? 1'b1 : bits[i/CPB];
    end
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("reset_valid", int'(valid), 0);
    chk("reset_data", int'(data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ferr", int'(ferr), 0);
    chk("reset_ovr", int'(ovr), 0);
    nreset = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frame, latency = 2 + 8 + 9*16 + 1 cycles, +/-1.
    ready    = 1'b1;
    rise_cyc = -1;
    push(0, 8'hA5);
    frame(8'hA5, 1'b1, -1, -1);
    chk("latency_in_range",
        int'((rise_cyc - c0) >= 154 && (rise_cyc - c0) <= 156), 1);
    chk("a5_valid_one_cycle", int'(valid), 0);

    // Short low glitch on an idle line.
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy", int'(busy), 1);
    repeat (20) @(negedge clk);
    chk("glitch_idle", int'(busy), 0);
    chk("glitch_valid", int'(valid), 0);

    // Bad stop bit, then a good frame.
    push(1, 8'h00);
    frame(8'h3C, 1'b0, -1, -1);
    chk("ferr_valid", int'(valid), 0);
    push(0, 8'h81);
    frame(8'h81, 1'b1, -1, -1);

    // Overrun with the slot held.
    ready = 1'b0;
    frame(8'h11, 1'b1, -1, -1);
    push(2, 8'h00);
    push(0, 8'h11);
    frame(8'h22, 1'b1, -1, -1);
    chk("ovr_valid_held", int'(valid), 1);
    chk("ovr_data_held", int'(data), 8'h11);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("consume_clears", int'(valid), 0);

    // Consume exactly in the stop-sample cycle of the next byte.
    frame(8'h11, 1'b1, -1, -1);
    push(0, 8'h11);
    frame(8'h22, 1'b1, 154, -1);
    chk("reload_valid_after", int'(valid), 1);
    chk("reload_data_after", int'(data), 8'h22);
    push(0, 8'h22);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;

    // Reset during data bit 3, then a clean frame.
    frame(8'h7E, 1'b1, -1, 66);
    chk("post_rst_valid", int'(valid), 0);
    ready = 1'b1;
    push(0, 8'h55);
    frame(8'h55, 1'b1, -1, -1);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
